// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   SVGA 800x600 @ 56 Hz timing generator and registered RGB/sync output stage.
//   Coordinates go out to the renderer, its combinational colour comes back in
//   and is registered together with the syncs so that colour, blanking and
//   sync leave the FPGA mutually aligned, one cycle after the coordinates.
//
// Ports
//   pixel_clk                  in   pixel clock (36 MHz)
//   rst                        in   asynchronous, active-high reset
//   h_coord, v_coord   [9:0]   out  horizontal / vertical counters
//   display_on                 out  visible-region decode of the counters
//   frame_start                out  one-cycle pulse while counters read (0,0)
//   red_in/green_in/blue_in    in   renderer colour for current coordinates
//   vga_r/vga_g/vga_b  [3:0]   out  registered colour, black in blanking
//   vga_hs, vga_vs             out  registered syncs (polarity per HS_POL/VS_POL)
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 72,
  parameter int unsigned H_BP     = 128,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 22,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1
) (
  input  logic       pixel_clk,
  input  logic       rst,
  output logic [9:0] h_coord,
  output logic [9:0] v_coord,
  output logic       display_on,
  output logic       frame_start,
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Counters are 10 bits wide; larger totals cannot be represented.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       h_wrap;
  logic       hs_region;
  logic       vs_region;

  always_comb begin
    h_wrap = (h_coord == H_LAST);
    h_next = h_wrap ? '0 : h_coord + 10'd1;
    v_next = v_coord;
    if (h_wrap) begin
      v_next = (v_coord == V_LAST) ? '0 : v_coord + 10'd1;
    end
  end

  // Compare in 11 bits so a region end of exactly 1024 stays representable.
  always_comb begin
    display_on = ({1'b0, h_coord} < 11'(H_ACTIVE)) &&
                 ({1'b0, v_coord} < 11'(V_ACTIVE));
    hs_region  = ({1'b0, h_coord} >= 11'(HS_START)) &&
                 ({1'b0, h_coord} <  11'(HS_END));
    vs_region  = ({1'b0, v_coord} >= 11'(VS_START)) &&
                 ({1'b0, v_coord} <  11'(VS_END));
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      h_coord     <= '0;
      v_coord     <= '0;
      frame_start <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= ~HS_POL;
      vga_vs      <= ~VS_POL;
    end else begin
      h_coord     <= h_next;
      v_coord     <= v_next;
      // Decoded from the next state so the pulse lines up with (0,0); the
      // reset-time (0,0) is never a "next" state, so the first frame is silent.
      frame_start <= (h_next == '0) && (v_next == '0);
      vga_r       <= display_on ? red_in   : '0;
      vga_g       <= display_on ? green_in : '0;
      vga_b       <= display_on ? blue_in  : '0;
      vga_hs      <= hs_region ? HS_POL : ~HS_POL;
      vga_vs      <= vs_region ? VS_POL : ~VS_POL;
    end
  end

endmodule
